cmd_frame_tx: RTL
=================

# cmd_frame_tx

- Host-side command frame serializer placed directly upstream of the system's UART receive input.
- Accepts one decoded command per handshake and expands it into the system's byte-level command frame.
- Transmits the frame as back-to-back UART characters on a single serial line.
- Used as the stimulus/driver stage for the UART_RX_IN pin in system-level benches and in the FPGA host bridge.

## Interface
- DATA_WIDTH, 8, UART character width and payload byte width
- BAUD_W, 16, width of the bit-period divisor
- CLK  in  1  single clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- CMD_TYPE  in  2  0=RF write, 1=RF read, 2=ALU with operands, 3=ALU no operands
- CMD_ADDR  in  4  register file address
- CMD_DATA0  in  DATA_WIDTH  RF write data / ALU operand A
- CMD_DATA1  in  DATA_WIDTH  ALU operand B
- CMD_FUN  in  4  ALU function code
- CMD_VLD  in  1  command valid
- CMD_RDY  out  1  ready; high only in IDLE
- BAUD_DIV  in  BAUD_W  CLK cycles per UART bit
- PAR_EN  in  1  parity enable
- PAR_TYPE  in  1  0=even, 1=odd
- TX_OUT  out  1  serial output, idle high
- BUSY  out  1  high while a frame is in flight
- FRAME_DONE  out  1  one-cycle pulse at frame end

## Operation
- Handshake: a command is accepted on a rising edge where CMD_VLD && CMD_RDY.
- At acceptance, all CMD_* fields and BAUD_DIV/PAR_EN/PAR_TYPE are latched. Input changes during the frame are ignored.
- Frame bytes, sent in order:
  - RF write: 0xAA, {4'b0,ADDR}, DATA0
  - RF read: 0xBB, {4'b0,ADDR}
  - ALU with operands: 0xCC, DATA0, DATA1, {4'b0,FUN}
  - ALU no operands: 0xDD, {4'b0,FUN}
- Character format: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1.
- Parity bit = XOR of the data bits, inverted when PAR_TYPE=1.
- FSM states: IDLE -> START -> DATA (8 bits) -> PARITY (only if latched PAR_EN) -> STOP.
  - After STOP: go to START if bytes remain, otherwise IDLE.
- Counters:
  - Baud counter runs 0..BAUD_DIV-1; the bit advances on terminal count.
  - Bit index runs 0..7.
  - Byte index runs 0..len-1; len is 2, 3 or 4.
- Effective divisor = max(BAUD_DIV, 2); values 0 and 1 are treated as 2.
- BUSY = (state != IDLE).
- CMD_RDY = (state == IDLE).
- TX_OUT is registered and glitch-free.
- Reset mid-frame: the frame is abandoned immediately; TX_OUT goes high asynchronously. No FRAME_DONE is generated.

## Timing
- Reset values: TX_OUT=1, BUSY=0, FRAME_DONE=0, CMD_RDY=1; all counters 0; state IDLE.
- Accept at edge k: TX_OUT=0 (start bit) and BUSY=1 from edge k+1.
- Every bit lasts exactly D = max(BAUD_DIV,2) cycles.
- No idle gap between bytes: the stop bit of byte i is followed directly by the start bit of byte i+1.
- Frame length = len × (10 + PAR_EN) × D cycles.
- FRAME_DONE timing:
  - It is high for exactly the one cycle after the last stop bit completes.
  - In that cycle state=IDLE, CMD_RDY=1, BUSY=0.
- A command presented during the FRAME_DONE cycle is accepted in that cycle. This gives exactly one extra idle-high cycle between frames, the minimum inter-frame gap.
- CMD_VLD held high with CMD_RDY low has no effect; no queueing.

## Configuration
- Macro: CMD_FRAME_TX_PARITY_EN.
- Defined: PAR_EN/PAR_TYPE behave as above; characters are 10 or 11 bits.
- Undefined:
  - The parity logic and PARITY state are not compiled.
  - PAR_EN/PAR_TYPE ports remain but are ignored.
  - Every character is 10 bits.

## Test plan
- RF write, BAUD_DIV=4, PAR_EN=0, ADDR=0x3, DATA0=0x5A:
  - TX_OUT carries 0xAA, 0x03, 0x5A in 120 cycles.
  - FRAME_DONE pulses at cycle 121 after accept.
- RF read, BAUD_DIV=4, PAR_EN=1, PAR_TYPE=0, ADDR=0x2:
  - Bytes 0xBB (parity 0) and 0x02 (parity 1) in 88 cycles.
  - Repeat with PAR_TYPE=1: parity bits invert.
- ALU with operands, DATA0=0x10, DATA1=0x05, FUN=0x0, BAUD_DIV=8:
  - Bytes 0xCC, 0x10, 0x05, 0x00 in 320 cycles.
  - CMD_RDY stays low throughout.
- Back-to-back: CMD_VLD held high with ALU no-op FUN=0x2, then RF read ADDR=0x1:
  - Frames DD,02 and BB,01 separated by exactly one idle-high cycle.
- Edge cases:
  - BAUD_DIV=0 gives 2-cycle bits.
  - RST asserted mid-DATA of the 2nd byte: TX_OUT=1 immediately, CMD_RDY=1 after release, no FRAME_DONE.
  - A subsequent command transmits correctly.

Source files
------------

// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx
// Turns one decoded host command into a UART byte frame and shifts it out
// on a single serial line, with no gap between characters.
//
// Frames by command type:
//   0 RF write : AA, {0,addr}, data0
//   1 RF read  : BB, {0,addr}
//   2 ALU ops  : CC, data0, data1, {0,fun}
//   3 ALU only : DD, {0,fun}
// Each character is: start(0), data LSB first, [parity], stop(1).
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   cmd_type/addr/data0/data1/fun, cmd_vld, cmd_rdy   command handshake
//   baud_div         clock cycles per bit (0 and 1 are treated as 2)
//   par_en, par_type parity enable, 0=even 1=odd
//   tx_out           registered serial output, idle high
//   busy, frame_done frame in flight, one-cycle end-of-frame pulse
//
// Configuration macro: CMD_FRAME_TX_PARITY_EN
//   defined   : parity bit sent when par_en was high at acceptance
//   undefined : no parity logic, par_en/par_type ignored, 10-bit characters
module cmd_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cmd_type,
    input  logic [3:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data0,
    input  logic [DATA_WIDTH-1:0] cmd_data1,
    input  logic [3:0]            cmd_fun,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [BAUD_W-1:0]     baud_div,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BI = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef CMD_FRAME_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state, state_next;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BAUD_W-1:0]     lat_div;
    logic [BI-1:0]         bit_idx;
    logic [BI-1:0]         bit_sel;
    logic [1:0]            byte_idx;
    logic [1:0]            last_idx;
    logic [1:0]            lat_type;
    logic [3:0]            lat_addr;
    logic [3:0]            lat_fun;
    logic [DATA_WIDTH-1:0] lat_data0;
    logic [DATA_WIDTH-1:0] lat_data1;
    logic [DATA_WIDTH-1:0] cur_byte;
    logic [BAUD_W-1:0]     eff_div;
    logic                  baud_tc;
    logic                  last_bit;
    logic                  last_byte;
    logic                  tx_next;
    logic                  tx_q;
    logic                  done_q;

`ifdef CMD_FRAME_TX_PARITY_EN
    logic                  lat_par_en;
    logic                  lat_par_type;
`else
    logic                  unused_par;
    assign unused_par = par_en ^ par_type;
`endif

    assign eff_div   = (baud_div < BAUD_W'(2)) ? BAUD_W'(2) : baud_div;
    assign baud_tc   = (baud_cnt == lat_div - BAUD_W'(1));
    assign last_bit  = (bit_idx == BI'(DATA_WIDTH - 1));
    assign last_byte = (byte_idx == last_idx);

    assign cmd_rdy    = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign tx_out     = tx_q;
    assign frame_done = done_q;

    // Byte currently on the wire, selected from the latched command by
    // its position in the frame; also gives the index of the final byte.
    always_comb begin
        cur_byte = '0;
        last_idx = 2'd1;
        case (lat_type)
            2'd0: begin
                last_idx = 2'd2;
                case (byte_idx)
                    2'd0:    cur_byte = DATA_WIDTH'(8'hAA);
                    2'd1:    cur_byte = DATA_WIDTH'(lat_addr);
                    default: cur_byte = lat_data0;
                endcase
            end
            2'd1: begin
                last_idx = 2'd1;
                cur_byte = (byte_idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(lat_addr);
            end
            2'd2: begin
                last_idx = 2'd3;
                case (byte_idx)
                    2'd0:    cur_byte = DATA_WIDTH'(8'hCC);
                    2'd1:    cur_byte = lat_data0;
                    2'd2:    cur_byte = lat_data1;
                    default: cur_byte = DATA_WIDTH'(lat_fun);
                endcase
            end
            default: begin
                last_idx = 2'd1;
                cur_byte = (byte_idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(lat_fun);
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next state, plus the line level for the cycle after this edge so that
    // tx_out can be a plain flop and change exactly on bit boundaries.
    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        bit_sel    = (state == S_START) ? BI'(0) :
                     (baud_tc ? BI'(bit_idx + 1'b1) : bit_idx);
        case (state)
            S_IDLE:  if (cmd_vld) state_next = S_START;
            S_START: if (baud_tc) state_next = S_DATA;
            S_DATA: begin
                if (baud_tc && last_bit) begin
`ifdef CMD_FRAME_TX_PARITY_EN
                    state_next = lat_par_en ? S_PARITY : S_STOP;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef CMD_FRAME_TX_PARITY_EN
            S_PARITY: if (baud_tc) state_next = S_STOP;
`endif
            S_STOP: if (baud_tc) state_next = last_byte ? S_IDLE : S_START;
            default: state_next = S_IDLE;
        endcase
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = cur_byte[bit_sel];
`ifdef CMD_FRAME_TX_PARITY_EN
            S_PARITY: tx_next = (^cur_byte) ^ lat_par_type;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    // Datapath: command latch at acceptance, baud/bit/byte counters, the
    // registered line and the end-of-frame pulse raised as STOP completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            lat_div   <= BAUD_W'(2);
            lat_type  <= '0;
            lat_addr  <= '0;
            lat_fun   <= '0;
            lat_data0 <= '0;
            lat_data1 <= '0;
`ifdef CMD_FRAME_TX_PARITY_EN
            lat_par_en   <= 1'b0;
            lat_par_type <= 1'b0;
`endif
        end else begin
            tx_q   <= tx_next;
            done_q <= 1'b0;
            if (state == S_IDLE) begin
                if (cmd_vld) begin
                    baud_cnt  <= '0;
                    bit_idx   <= '0;
                    byte_idx  <= '0;
                    lat_div   <= eff_div;
                    lat_type  <= cmd_type;
                    lat_addr  <= cmd_addr;
                    lat_fun   <= cmd_fun;
                    lat_data0 <= cmd_data0;
                    lat_data1 <= cmd_data1;
`ifdef CMD_FRAME_TX_PARITY_EN
                    lat_par_en   <= par_en;
                    lat_par_type <= par_type;
`endif
                end
            end else begin
                baud_cnt <= baud_tc ? '0 : baud_cnt + BAUD_W'(1);
                if (baud_tc && state == S_DATA)
                    bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
                if (baud_tc && state == S_STOP) begin
                    if (last_byte) done_q   <= 1'b1;
                    else           byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule
